// File: rtl/mont_redc34_if.sv
// Handshake bundle for the Montgomery reduction stage: product/modulus in, residue out.
interface mont_redc34_if #(parameter int W = 34);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] t_in;
  logic [W-1:0]   n_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   r_out;
  logic           busy;

  modport master (
    output in_valid, t_in, n_in, out_ready,
    input  in_ready, out_valid, r_out, busy
  );

  modport slave (
    input  in_valid, t_in, n_in, out_ready,
    output in_ready, out_valid, r_out, busy
  );
endinterface

// File: rtl/mont_redc34.sv
// Bit-serial Montgomery REDC, T*2^-W mod N; out_valid W+1 cycles after accept.
// Single-entry: in_ready only in IDLE, result held in DONE until out_ready.
module mont_redc34 #(
  parameter int W = 34
) (
  input  logic        clk,
  input  logic        rst,
  mont_redc34_if.slave bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, REDUCE, FINAL, DONE} state_t;

  state_t         state;
  logic [2*W:0]   acc;
  logic [W-1:0]   nreg;
  logic [CW-1:0]  cnt;
  logic [2*W:0]   n_ext;

  assign n_ext = {{(W+1){1'b0}}, nreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.r_out     <= '0;
      acc           <= '0;
      cnt           <= '0;
      nreg          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc          <= {1'b0, bus.t_in};
            nreg         <= bus.n_in;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= REDUCE;
          end
        end
        REDUCE: begin
          // Adding N when odd makes the sum even, so the shift is exact division by 2 mod N.
          acc <= (acc + (acc[0] ? n_ext : '0)) >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1))
            state <= FINAL;
        end
        FINAL: begin
          // acc < 2N here, so one conditional subtraction lands in [0, N).
          if (acc >= n_ext)
            bus.r_out <= acc[W-1:0] - nreg;
          else
            bus.r_out <= acc[W-1:0];
          bus.out_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_redc34.sv
// Directed and reference-model checks of mont_redc34: latency, residues, backpressure, reset abort.
module tb_mont_redc34;
  localparam int W = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  mont_redc34_if #(.W(W)) bus ();

  mont_redc34 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2*W-1:0] t, input logic [W-1:0] n);
    int w = 0;
    while (!bus.in_ready && w < 100) begin
      tick();
      w++;
    end
    chk("issue_rdy", 69'(bus.in_ready), 69'(1));
    bus.t_in     = t;
    bus.n_in     = n;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [W-1:0] exp_r, input int exp_lat, input bit ack);
    int lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 69'(lat), 69'(exp_lat));
    chk({tag, "_r"}, 69'(bus.r_out), 69'(exp_r));
    if (ack) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_ovlow"}, 69'(bus.out_valid), 69'(0));
    end
  endtask

  function automatic longint modinv(input longint a, input longint m);
    longint t = 0, nt = 1, r = m, nr = a, q, tmp;
    while (nr != 0) begin
      q   = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t += m;
    return t;
  endfunction

  function automatic logic [W-1:0] ref_redc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
    logic [127:0] p, rm, inv;
    p   = (128'(a) * 128'(b)) % 128'(n);
    rm  = (128'(1) << W) % 128'(n);
    inv = 128'(modinv(longint'(rm), longint'(n)));
    p   = (p * inv) % 128'(n);
    return p[W-1:0];
  endfunction

  initial begin
    logic [63:0]  r64;
    logic [W-1:0] n, a, b;
    int           seen;

    bus.in_valid  = 1'b0;
    bus.t_in      = '0;
    bus.n_in      = '0;
    bus.out_ready = 1'b1;

    repeat (3) begin
      tick();
      chk("rst_in_ready", 69'(bus.in_ready), 69'(1));
      chk("rst_out_valid", 69'(bus.out_valid), 69'(0));
      chk("rst_busy", 69'(bus.busy), 69'(0));
      chk("rst_r_out", 69'(bus.r_out), 69'(0));
    end
    rst = 1'b0;
    tick();
    chk("idle_ovlow", 69'(bus.out_valid), 69'(0));
    chk("idle_rdy", 69'(bus.in_ready), 69'(1));
    bus.out_ready = 1'b0;

    issue(68'(5) << 34, 34'h3_FFFF_FFFF);
    collect("radix", 34'd5, 35, 1'b1);
    chk("radix_rdy", 69'(bus.in_ready), 69'(1));

    issue(68'(1) << 34, 34'd13);
    collect("n13_r1", 34'd1, 35, 1'b1);
    issue(68'd0, 34'd13);
    collect("n13_t0", 34'd0, 35, 1'b1);

    issue(68'd13, 34'd13);
    repeat (34) tick();
    chk("final_state", 69'(dut.state), 69'(2));
    chk("final_acc", 69'(dut.acc), 69'(13));
    collect("n13_t13", 34'd0, 1, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      r64 = {$urandom, $urandom};
      n   = r64[W-1:0] | 34'd1;
      if (n < 3) n = 34'd3;
      r64 = {$urandom, $urandom};
      a   = W'(r64 % 64'(n));
      r64 = {$urandom, $urandom};
      b   = W'(r64 % 64'(n));
      issue(68'(a) * 68'(b), n);
      collect("rand", ref_redc(a, b, n), 35, 1'b1);
    end

    issue(68'(1) << 34, 34'd13);
    collect("bp1", 34'd1, 35, 1'b0);
    bus.t_in     = 68'(5) << 34;
    bus.n_in     = 34'h3_FFFF_FFFF;
    bus.in_valid = 1'b1;
    repeat (10) begin
      tick();
      chk("bp_r_hold", 69'(bus.r_out), 69'(1));
      chk("bp_ov_hold", 69'(bus.out_valid), 69'(1));
      chk("bp_rdy_low", 69'(bus.in_ready), 69'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_hs_ov", 69'(bus.out_valid), 69'(0));
    chk("bp_hs_rdy", 69'(bus.in_ready), 69'(1));
    chk("bp_hs_busy", 69'(bus.busy), 69'(0));
    tick();
    bus.in_valid = 1'b0;
    chk("bp2_busy", 69'(bus.busy), 69'(1));
    chk("bp2_rdy", 69'(bus.in_ready), 69'(0));
    collect("bp2", 34'd5, 35, 1'b1);

    issue(68'(7) << 34, 34'h3_FFFF_FFFF);
    repeat (17) tick();
    chk("abort_cnt", 69'(dut.cnt), 69'(17));
    chk("abort_state", 69'(dut.state), 69'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rdy", 69'(bus.in_ready), 69'(1));
    chk("abort_ov", 69'(bus.out_valid), 69'(0));
    chk("abort_busy", 69'(bus.busy), 69'(0));
    chk("abort_r", 69'(bus.r_out), 69'(0));
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("abort_no_ov", 69'(seen), 69'(0));
    issue(68'(1) << 34, 34'd13);
    collect("post_rst", 34'd1, 35, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
